// File: rtl/bf_tape_unit.sv
// ============================================================================
// bf_tape_unit : BF CPU data tape with cell pointer, signed-delta ADD/MOVE,
//                LOAD, CLEAR and a post-reset zeroing sweep.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_tape_unit #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int DELTA_W = 8,
  parameter int WRAP    = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic [DELTA_W-1:0] op_delta,
  input  logic [WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]   cell_out,
  output logic               cell_zero,
  output logic [AW-1:0]      ptr,
  output logic               op_illegal
);

  localparam logic [2:0] c_OP_NOP   = 3'd0;
  localparam logic [2:0] c_OP_ADD   = 3'd1;
  localparam logic [2:0] c_OP_MOVE  = 3'd2;
  localparam logic [2:0] c_OP_LOAD  = 3'd3;
  localparam logic [2:0] c_OP_CLEAR = 3'd4;

  // Two guard bits: unsigned cell plus signed delta can exceed 2^WIDTH-1
  // and still needs a sign bit for the saturation compare.
  localparam int EW = ((WIDTH > DELTA_W) ? WIDTH : DELTA_W) + 2;
  localparam int SW = ((AW > DELTA_W) ? AW : DELTA_W) + 1;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [AW-1:0]      r_idx, w_idx_next;
  logic [AW-1:0]      r_ptr, w_ptr_next;
  logic               r_illegal, w_illegal_next;
  logic [WIDTH-1:0]   r_tape [DEPTH];

  logic               w_accept;
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic [WIDTH-1:0]   w_wdata;
  logic [WIDTH-1:0]   w_cur;
  logic signed [EW-1:0] w_cell_ext, w_delta_ext, w_sum, w_max;
  logic [WIDTH-1:0]   w_add_res;
  logic [SW-1:0]      w_dsx;
  logic [AW-1:0]      w_ptr_moved;
  logic               w_unused;

  assign w_cur       = r_tape[r_ptr];
  assign w_cell_ext  = signed'({{(EW-WIDTH){1'b0}}, w_cur});
  assign w_delta_ext = signed'({{(EW-DELTA_W){op_delta[DELTA_W-1]}}, op_delta});
  assign w_sum       = w_cell_ext + w_delta_ext;
  assign w_max       = signed'({{(EW-WIDTH){1'b0}}, {WIDTH{1'b1}}});

  always_comb begin
    w_add_res = w_sum[WIDTH-1:0];
    if (WRAP == 0) begin
      if (w_sum[EW-1])
        w_add_res = '0;
      else if (w_sum > w_max)
        w_add_res = {WIDTH{1'b1}};
    end
  end

  // Pointer arithmetic is always modulo DEPTH regardless of cell mode.
  assign w_dsx       = {{(SW-DELTA_W){op_delta[DELTA_W-1]}}, op_delta};
  assign w_ptr_moved = r_ptr + w_dsx[AW-1:0];
  assign w_unused    = ^w_dsx[SW-1:AW];

  assign op_ready   = (r_state == ST_RUN);
  assign w_accept   = op_valid && op_ready;
  assign cell_out   = (r_state == ST_SWEEP) ? '0 : w_cur;
  assign cell_zero  = (cell_out == '0);
  assign ptr        = r_ptr;
  assign op_illegal = r_illegal;

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_ptr_next     = r_ptr;
    w_illegal_next = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_ptr;
    w_wdata        = w_add_res;
    case (r_state)
      ST_SWEEP: begin
        w_we       = 1'b1;
        w_waddr    = r_idx;
        w_wdata    = '0;
        w_idx_next = r_idx + 1'b1;
        if (r_idx == AW'(DEPTH - 1))
          w_state_next = ST_RUN;
      end
      default: begin
        if (w_accept) begin
          case (op_code)
            c_OP_NOP:  ;
            c_OP_ADD:  w_we = 1'b1;
            c_OP_MOVE: w_ptr_next = w_ptr_moved;
            c_OP_LOAD: begin
              w_we    = 1'b1;
              w_wdata = in_data;
            end
            c_OP_CLEAR: begin
              w_ptr_next   = '0;
              w_idx_next   = '0;
              w_state_next = ST_SWEEP;
            end
            default:   w_illegal_next = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SWEEP;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_ptr     <= w_ptr_next;
      r_illegal <= w_illegal_next;
    end
  end

  // Storage is deliberately unreset; the sweep zeroes it before first use.
  always_ff @(posedge clk) begin
    if (w_we)
      r_tape[w_waddr] <= w_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_bf_tape_unit.sv
// ============================================================================
// tb_bf_tape_unit : directed bench for bf_tape_unit (wrap, saturate, 12-bit).
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf_tape_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic [7:0] op_delta = 8'd0;
  logic [7:0] in_data = 8'd0;

  logic       rdy_w, zero_w, ill_w;
  logic [7:0] cell_w;
  logic [3:0] ptr_w;
  logic       rdy_s, zero_s, ill_s;
  logic [7:0] cell_s;
  logic [3:0] ptr_s;
  logic       rdy_t, zero_t, ill_t;
  logic [11:0] cell_t;
  logic [3:0] ptr_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bf_tape_unit #(.WIDTH(8), .DEPTH(16), .DELTA_W(8), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy_w),
    .op_code(op_code), .op_delta(op_delta), .in_data(in_data),
    .cell_out(cell_w), .cell_zero(zero_w), .ptr(ptr_w), .op_illegal(ill_w));

  bf_tape_unit #(.WIDTH(8), .DEPTH(16), .DELTA_W(8), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy_s),
    .op_code(op_code), .op_delta(op_delta), .in_data(in_data),
    .cell_out(cell_s), .cell_zero(zero_s), .ptr(ptr_s), .op_illegal(ill_s));

  bf_tape_unit #(.WIDTH(12), .DEPTH(16), .DELTA_W(4), .WRAP(1)) dut_w12 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy_t),
    .op_code(op_code), .op_delta(op_delta[3:0]), .in_data({4'h0, in_data}),
    .cell_out(cell_t), .cell_zero(zero_t), .ptr(ptr_t), .op_illegal(ill_t));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one op for a single edge; caller guarantees op_ready is high.
  task automatic do_op(input logic [2:0] c, input logic [7:0] d, input logic [7:0] x);
    op_code  = c;
    op_delta = d;
    in_data  = x;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy_w && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rdy_w, 0);
    check("rst_cell",  cell_w, 8'h00);
    check("rst_zero",  zero_w, 1);
    check("rst_ptr",   ptr_w, 0);
    check("rst_ill",   ill_w, 0);

    // Abort a sweep part-way, then hold an ADD through the restarted sweep.
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("sweep5_ready", rdy_w, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", rdy_w, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    op_code  = 3'd1;
    op_delta = 8'd1;
    op_valid = 1'b1;
    wait_ready(n);
    check("sweep_len", n, 16);
    check("held_cell_before", cell_w, 8'h00);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("held_cell_after", cell_w, 8'h01);

    do_op(3'd3, 8'h00, 8'hAD);
    check("load_ad", cell_w, 8'hAD);
    check("load_ill", ill_w, 0);
    do_op(3'd1, 8'hFF, 8'h00);
    check("add_m1", cell_w, 8'hAC);
    do_op(3'd1, 8'h02, 8'h00);
    check("add_p2", cell_w, 8'hAE);
    do_op(3'd1, 8'h00, 8'h00);
    check("add_0", cell_w, 8'hAE);

    op_code  = 3'd1;
    op_delta = 8'h01;
    op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b_ready", rdy_w, 1);
    end
    op_valid = 1'b0;
    check("b2b_wrap", cell_w, 8'hB1);
    check("b2b_sat",  cell_s, 8'hB1);

    do_op(3'd3, 8'h00, 8'hFF);
    do_op(3'd1, 8'h01, 8'h00);
    check("wrap_ff_p1", cell_w, 8'h00);
    check("wrap_ff_zero", zero_w, 1);
    check("sat_ff_p1", cell_s, 8'hFF);
    check("sat_ff_zero", zero_s, 0);

    do_op(3'd3, 8'h00, 8'hFE);
    do_op(3'd1, 8'h05, 8'h00);
    check("wrap_fe_p5", cell_w, 8'h03);
    check("sat_fe_p5",  cell_s, 8'hFF);

    do_op(3'd3, 8'h00, 8'h10);
    do_op(3'd1, 8'h80, 8'h00);
    check("wrap_10_m128", cell_w, 8'h90);
    check("sat_10_m128",  cell_s, 8'h00);

    do_op(3'd3, 8'h00, 8'h00);
    do_op(3'd1, 8'hF8, 8'h00);
    check("w12_0_m8", cell_t, 12'hFF8);
    check("sat_0_m8", cell_s, 8'h00);

    do_op(3'd3, 8'h00, 8'h00);
    do_op(3'd2, 8'hFF, 8'h00);
    check("mv_m1_ptr",  ptr_w, 4'd15);
    check("mv_m1_cell", cell_w, 8'h00);
    do_op(3'd3, 8'h00, 8'h55);
    do_op(3'd2, 8'h01, 8'h00);
    check("mv_p1_ptr",  ptr_w, 4'd0);
    check("mv_p1_cell", cell_w, 8'h00);
    do_op(3'd2, 8'h1F, 8'h00);
    check("mv_p31_ptr",  ptr_w, 4'd15);
    check("mv_p31_cell", cell_w, 8'h55);

    do_op(3'd6, 8'h01, 8'h00);
    check("ill_pulse", ill_w, 1);
    check("ill_ptr",   ptr_w, 4'd15);
    check("ill_cell",  cell_w, 8'h55);
    @(posedge clk); #1;
    check("ill_drop", ill_w, 0);

    do_op(3'd2, 8'h01, 8'h00);
    for (int i = 0; i < 4; i++) begin
      do_op(3'd3, 8'h00, 8'h11);
      if (i < 3) do_op(3'd2, 8'h01, 8'h00);
    end
    check("pre_clr_ptr",  ptr_w, 4'd3);
    check("pre_clr_cell", cell_w, 8'h11);
    do_op(3'd4, 8'h00, 8'h00);
    check("clr_ready", rdy_w, 0);
    check("clr_ptr",   ptr_w, 4'd0);
    check("clr_zero",  zero_w, 1);
    wait_ready(n);
    check("clr_len", n, 16);
    check("clr_c0", cell_w, 8'h00);
    for (int i = 1; i < 4; i++) begin
      do_op(3'd2, 8'h01, 8'h00);
      check("clr_cn", cell_w, 8'h00);
    end
    do_op(3'd2, 8'hFC, 8'h00);
    check("clr_c15_ptr",  ptr_w, 4'd15);
    check("clr_c15_cell", cell_w, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
